// File: rtl/vga_pkg.sv
// Shared VGA timing constants, rectangle register map and reset bounds.
// Defaults describe 640x480@60Hz from a 50 MHz clock with a 25 MHz pixel enable.
package vga_pkg;

  localparam int DFLT_H_VIS  = 640;
  localparam int DFLT_H_FP   = 16;
  localparam int DFLT_H_SYNC = 96;
  localparam int DFLT_H_BP   = 48;
  localparam int DFLT_V_VIS  = 480;
  localparam int DFLT_V_FP   = 10;
  localparam int DFLT_V_SYNC = 2;
  localparam int DFLT_V_BP   = 33;
  localparam logic [7:0] DFLT_BASE_ID = 8'h10;

  localparam int H_TOTAL      = DFLT_H_VIS + DFLT_H_FP + DFLT_H_SYNC + DFLT_H_BP;
  localparam int V_TOTAL      = DFLT_V_VIS + DFLT_V_FP + DFLT_V_SYNC + DFLT_V_BP;
  localparam int H_SYNC_START = DFLT_H_VIS + DFLT_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DFLT_H_SYNC - 1;
  localparam int V_SYNC_START = DFLT_V_VIS + DFLT_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DFLT_V_SYNC - 1;

  typedef enum logic [2:0] {
    OFF_X0_LO = 3'd0,
    OFF_X0_HI = 3'd1,
    OFF_X1_LO = 3'd2,
    OFF_X1_HI = 3'd3,
    OFF_Y0_LO = 3'd4,
    OFF_Y0_HI = 3'd5,
    OFF_Y1_LO = 3'd6,
    OFF_Y1_HI = 3'd7
  } reg_off_e;

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
  } rect_t;

  localparam logic [9:0] RST_X0 = 10'd190;
  localparam logic [9:0] RST_X1 = 10'd550;
  localparam logic [9:0] RST_Y0 = 10'd100;
  localparam logic [9:0] RST_Y1 = 10'd370;
  localparam rect_t RST_RECT = {RST_X0, RST_X1, RST_Y0, RST_Y1};

endpackage

// File: rtl/vga_sync_gen.sv
// Pixel enable, h/v counters and sync decode; syncs are registered from the
// next-state counts so they line up with hcount/vcount on the same clk.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_VIS  = DFLT_H_VIS,
  parameter int H_FP   = DFLT_H_FP,
  parameter int H_SYNC = DFLT_H_SYNC,
  parameter int H_BP   = DFLT_H_BP,
  parameter int V_VIS  = DFLT_V_VIS,
  parameter int V_FP   = DFLT_V_FP,
  parameter int V_SYNC = DFLT_V_SYNC,
  parameter int V_BP   = DFLT_V_BP
) (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic [9:0] o_hcount,
  output logic [9:0] o_vcount,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_video_on,
  output logic       o_pixel_tick,
  output logic       o_frame_end
);

  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);

  logic       r_tick;
  logic [9:0] r_hcount;
  logic [9:0] r_vcount;
  logic       r_hsync;
  logic       r_vsync;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;

  assign w_h_wrap = (r_hcount == H_LAST);
  assign w_v_wrap = (r_vcount == V_LAST);

  always_comb begin
    w_h_nxt = r_hcount;
    w_v_nxt = r_vcount;
    if (r_tick) begin
      w_h_nxt = w_h_wrap ? 10'd0 : r_hcount + 10'd1;
      if (w_h_wrap) begin
        w_v_nxt = w_v_wrap ? 10'd0 : r_vcount + 10'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tick   <= 1'b0;
      r_hcount <= 10'd0;
      r_vcount <= 10'd0;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
    end else begin
      r_tick   <= ~r_tick;
      r_hcount <= w_h_nxt;
      r_vcount <= w_v_nxt;
      r_hsync  <= ~((w_h_nxt >= HS_FIRST) && (w_h_nxt <= HS_LAST));
      r_vsync  <= ~((w_v_nxt >= VS_FIRST) && (w_v_nxt <= VS_LAST));
    end
  end

  assign o_hcount     = r_hcount;
  assign o_vcount     = r_vcount;
  assign o_hsync      = r_hsync;
  assign o_vsync      = r_vsync;
  assign o_pixel_tick = r_tick;
  assign o_video_on   = (r_hcount < H_VIS_W) && (r_vcount < V_VIS_W);
  // Last pixel enable of the frame: the edge where bounds are committed.
  assign o_frame_end  = r_tick && w_h_wrap && w_v_wrap;

endmodule

// File: rtl/vga_rect_ctrl.sv
// Rectangle window controller: PicoBlaze-written pending bounds, committed to the
// active set at the frame boundary so a frame is always drawn with one bound set.
module vga_rect_ctrl
  import vga_pkg::*;
#(
  parameter int         H_VIS   = DFLT_H_VIS,
  parameter int         H_FP    = DFLT_H_FP,
  parameter int         H_SYNC  = DFLT_H_SYNC,
  parameter int         H_BP    = DFLT_H_BP,
  parameter int         V_VIS   = DFLT_V_VIS,
  parameter int         V_FP    = DFLT_V_FP,
  parameter int         V_SYNC  = DFLT_V_SYNC,
  parameter int         V_BP    = DFLT_V_BP,
  parameter logic [7:0] BASE_ID = DFLT_BASE_ID
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_port_id,
  input  logic [7:0] i_out_port,
  input  logic       i_write_strobe,
  output logic [9:0] o_hcount,
  output logic [9:0] o_vcount,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_video_on,
  output logic       o_pixel_tick,
  output logic       o_frame_start,
  output logic       o_rect_on
);

  logic [9:0] w_hcount;
  logic [9:0] w_vcount;
  logic       w_video_on;
  logic       w_frame_end;
  logic [7:0] w_rel;
  logic       w_wr;
  reg_off_e   w_off;
  rect_t      r_pend;
  rect_t      r_act;
  logic       r_frame_start;

  vga_sync_gen #(
    .H_VIS (H_VIS),  .H_FP (H_FP),  .H_SYNC (H_SYNC),  .H_BP (H_BP),
    .V_VIS (V_VIS),  .V_FP (V_FP),  .V_SYNC (V_SYNC),  .V_BP (V_BP)
  ) u_sync (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .o_hcount     (w_hcount),
    .o_vcount     (w_vcount),
    .o_hsync      (o_hsync),
    .o_vsync      (o_vsync),
    .o_video_on   (w_video_on),
    .o_pixel_tick (o_pixel_tick),
    .o_frame_end  (w_frame_end)
  );

  // Subtracting the base keeps the window decode correct even near 8'hFF.
  assign w_rel = i_port_id - BASE_ID;
  assign w_wr  = i_write_strobe && (w_rel[7:3] == 5'd0);
  assign w_off = reg_off_e'(w_rel[2:0]);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend        <= RST_RECT;
      r_act         <= RST_RECT;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_end;
      if (w_frame_end) begin
        r_act <= r_pend;
      end
      if (w_wr) begin
        case (w_off)
          OFF_X0_LO: r_pend.x0[7:0] <= i_out_port;
          OFF_X0_HI: r_pend.x0[9:8] <= i_out_port[1:0];
          OFF_X1_LO: r_pend.x1[7:0] <= i_out_port;
          OFF_X1_HI: r_pend.x1[9:8] <= i_out_port[1:0];
          OFF_Y0_LO: r_pend.y0[7:0] <= i_out_port;
          OFF_Y0_HI: r_pend.y0[9:8] <= i_out_port[1:0];
          OFF_Y1_LO: r_pend.y1[7:0] <= i_out_port;
          OFF_Y1_HI: r_pend.y1[9:8] <= i_out_port[1:0];
          default:   r_pend <= r_pend;
        endcase
      end
    end
  end

  assign o_hcount      = w_hcount;
  assign o_vcount      = w_vcount;
  assign o_video_on    = w_video_on;
  assign o_frame_start = r_frame_start;
  // Strict bounds: an empty or inverted window simply never matches.
  assign o_rect_on     = w_video_on &&
                         (w_hcount > r_act.x0) && (w_hcount < r_act.x1) &&
                         (w_vcount > r_act.y0) && (w_vcount < r_act.y1);

endmodule

// File: tb/tb_vga_rect_ctrl.sv
// Bench for vga_rect_ctrl on a shrunken raster, checked against a cycle-count based model.
module tb_vga_rect_ctrl;

  localparam int HV = 64, HF = 4, HS = 8, HB = 4;
  localparam int VV = 20, VF = 2, VS = 2, VB = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = 2 * HT * VT;
  localparam logic [7:0] BASE = 8'h10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pid = 8'd0;
  logic [7:0] dat = 8'd0;
  logic       we  = 1'b0;
  logic [9:0] o_h, o_v;
  logic       hs, vs, vid, tick, fs, rect;

  vga_rect_ctrl #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BASE_ID(BASE)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_port_id(pid), .i_out_port(dat), .i_write_strobe(we),
    .o_hcount(o_h), .o_vcount(o_v), .o_hsync(hs), .o_vsync(vs), .o_video_on(vid),
    .o_pixel_tick(tick), .o_frame_start(fs), .o_rect_on(rect)
  );

  always #5 clk = ~clk;

  // Model: k = clk edges since reset released; everything else follows from it.
  int         k;
  int         checks;
  int         passed;
  logic [9:0] pend [4];
  logic [9:0] act  [4];
  logic [9:0] dflt [4] = '{10'd190, 10'd550, 10'd100, 10'd370};

  function automatic int eh(); return (k / 2) % HT; endfunction
  function automatic int ev(); return (k / 2 / HT) % VT; endfunction
  function automatic logic evid(); return (eh() < HV) && (ev() < VV); endfunction
  function automatic logic ehs(); return !((eh() >= HV + HF) && (eh() < HV + HF + HS)); endfunction
  function automatic logic evs(); return !((ev() >= VV + VF) && (ev() < VV + VF + VS)); endfunction
  function automatic logic efs(); return (k > 0) && (k % FR == 0); endfunction
  function automatic logic erect();
    int h = eh();
    int v = ev();
    return evid() && (h > int'(act[0])) && (h < int'(act[1])) &&
           (v > int'(act[2])) && (v < int'(act[3]));
  endfunction

  task automatic model_edge();
    int rel;
    if (rst) begin
      k = 0;
      for (int i = 0; i < 4; i++) begin pend[i] = dflt[i]; act[i] = dflt[i]; end
    end else begin
      if ((k + 1) % FR == 0)
        for (int i = 0; i < 4; i++) act[i] = pend[i];
      rel = int'(pid) - int'(BASE);
      if (we && rel >= 0 && rel < 8) begin
        if (rel % 2 == 1) pend[rel / 2][9:8] = dat[1:0];
        else              pend[rel / 2][7:0] = dat;
      end
      k++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [7:0] p, input logic [7:0] d);
    pid = p; dat = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (o_h !== 10'd0) $display("FAIL rst_hcount got %0d want 0", o_h); else passed++;
    checks++; if (o_v !== 10'd0) $display("FAIL rst_vcount got %0d want 0", o_v); else passed++;
    checks++; if (hs !== 1'b1) $display("FAIL rst_hsync got %b want 1", hs); else passed++;
    checks++; if (vs !== 1'b1) $display("FAIL rst_vsync got %b want 1", vs); else passed++;
    checks++; if (tick !== 1'b0) $display("FAIL rst_tick got %b want 0", tick); else passed++;
    checks++; if (fs !== 1'b0) $display("FAIL rst_frame_start got %b want 0", fs); else passed++;
    checks++; if (vid !== 1'b1) $display("FAIL rst_video_on got %b want 1", vid); else passed++;
    checks++; if (rect !== 1'b0) $display("FAIL rst_rect_on got %b want 0", rect); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_timing();
    int bad_cnt = 0, bad_sync = 0, bad_fs = 0, bad_rect = 0;
    int hs_fall = -1, hs_per = 0, hs_nper = 0, hs_perr = 0, hs_w = 0, hs_nw = 0, hs_werr = 0;
    int vs_fall = -1, vs_per = 0, vs_nper = 0, vs_perr = 0, vs_w = 0, vs_nw = 0, vs_werr = 0;
    int fs_n = 0, fs_last = -1, fs_perr = 0;
    logic phs, pvs;
    phs = hs; pvs = vs;
    for (int c = 0; c < 2 * FR + 10; c++) begin
      step();
      if (o_h !== 10'(eh()) || o_v !== 10'(ev()) || tick !== 1'(k % 2) || vid !== evid()) bad_cnt++;
      if (hs !== ehs() || vs !== evs()) bad_sync++;
      if (fs !== efs()) bad_fs++;
      if (rect !== erect()) bad_rect++;
      if (phs && !hs) begin
        if (hs_fall >= 0) begin hs_per = k - hs_fall; hs_nper++; if (hs_per != 2 * HT) hs_perr++; end
        hs_fall = k;
      end
      if (!phs && hs && hs_fall >= 0) begin hs_w = k - hs_fall; hs_nw++; if (hs_w != 2 * HS) hs_werr++; end
      if (pvs && !vs) begin
        if (vs_fall >= 0) begin vs_per = k - vs_fall; vs_nper++; if (vs_per != FR) vs_perr++; end
        vs_fall = k;
      end
      if (!pvs && vs && vs_fall >= 0) begin vs_w = k - vs_fall; vs_nw++; if (vs_w != 2 * VS * HT) vs_werr++; end
      if (fs) begin
        if (fs_last >= 0 && k - fs_last != FR) fs_perr++;
        fs_last = k; fs_n++;
      end
      phs = hs; pvs = vs;
    end
    checks++; if (bad_cnt != 0) $display("FAIL counters mismatching_cycles=%0d want 0", bad_cnt); else passed++;
    checks++; if (bad_sync != 0) $display("FAIL sync_align mismatching_cycles=%0d want 0", bad_sync); else passed++;
    checks++; if (bad_fs != 0) $display("FAIL frame_start_track mismatching_cycles=%0d want 0", bad_fs); else passed++;
    checks++; if (bad_rect != 0) $display("FAIL rect_default mismatching_cycles=%0d want 0", bad_rect); else passed++;
    checks++; if (hs_nper == 0 || hs_perr != 0) $display("FAIL hsync_period last=%0d want %0d (bad=%0d n=%0d)", hs_per, 2 * HT, hs_perr, hs_nper); else passed++;
    checks++; if (hs_nw == 0 || hs_werr != 0) $display("FAIL hsync_low last=%0d want %0d (bad=%0d n=%0d)", hs_w, 2 * HS, hs_werr, hs_nw); else passed++;
    checks++; if (vs_nper == 0 || vs_perr != 0) $display("FAIL vsync_period last=%0d want %0d (bad=%0d n=%0d)", vs_per, FR, vs_perr, vs_nper); else passed++;
    checks++; if (vs_nw == 0 || vs_werr != 0) $display("FAIL vsync_low last=%0d want %0d (bad=%0d n=%0d)", vs_w, 2 * VS * HT, vs_werr, vs_nw); else passed++;
    checks++; if (fs_n != 2 || fs_perr != 0) $display("FAIL frame_start_count got %0d pulses (bad spacing %0d) want 2", fs_n, fs_perr); else passed++;
  endtask

  task automatic test_midframe_write();
    int f = 0, bad = 0;
    int first [3] = '{-1, -1, -1};
    bit wrote = 1'b0;
    wr(BASE, 8'd20);        wr(BASE + 8'd1, 8'd0);
    wr(BASE + 8'd2, 8'd50); wr(BASE + 8'd3, 8'd0);
    wr(BASE + 8'd4, 8'd5);  wr(BASE + 8'd5, 8'd0);
    wr(BASE + 8'd6, 8'd18); wr(BASE + 8'd7, 8'd0);
    for (int c = 0; c < 3 * FR && !(f == 2 && o_v > 10'd11); c++) begin
      if (f == 1 && !wrote && o_v == 10'd8) begin pid = BASE; dat = 8'd10; we = 1'b1; wrote = 1'b1; end
      step();
      we = 1'b0;
      if (fs) f++;
      if (rect !== erect()) bad++;
      if (rect && o_v == 10'd10 && f < 3 && first[f] < 0) first[f] = int'(o_h);
    end
    checks++; if (bad != 0) $display("FAIL midwrite_rect mismatching_cycles=%0d want 0", bad); else passed++;
    checks++; if (first[1] != 21) $display("FAIL midwrite_same_frame first_h=%0d want 21", first[1]); else passed++;
    checks++; if (first[2] != 11) $display("FAIL midwrite_next_frame first_h=%0d want 11", first[2]); else passed++;
  endtask

  task automatic test_commit_collision();
    int f = 0, bad = 0;
    int last [3] = '{-1, -1, -1};
    bit done = 1'b0, coll = 1'b0;
    logic fs_at_coll = 1'b0;
    for (int c = 0; c < 3 * FR && !(f == 2 && o_v > 10'd11); c++) begin
      if (!done && (k + 1) % FR == 0) begin
        pid = BASE + 8'd2; dat = 8'd30; we = 1'b1; done = 1'b1; coll = 1'b1;
      end
      step();
      we = 1'b0;
      if (coll) begin fs_at_coll = fs; coll = 1'b0; end
      if (fs) f++;
      if (rect !== erect()) bad++;
      if (rect && o_v == 10'd10 && f < 3) last[f] = int'(o_h);
    end
    checks++; if (fs_at_coll !== 1'b1) $display("FAIL collision_frame_start got %b want 1", fs_at_coll); else passed++;
    checks++; if (bad != 0) $display("FAIL collision_rect mismatching_cycles=%0d want 0", bad); else passed++;
    checks++; if (last[1] != 49) $display("FAIL collision_old_x1 last_h=%0d want 49", last[1]); else passed++;
    checks++; if (last[2] != 29) $display("FAIL collision_new_x1 last_h=%0d want 29", last[2]); else passed++;
  endtask

  task automatic test_inverted_oob();
    int f = 0, bad = 0, ones = 0;
    wr(BASE, 8'd60); wr(BASE + 8'd2, 8'd10);
    wr(BASE + 8'd8, 8'd0); wr(BASE + 8'd11, 8'd3); wr(BASE - 8'd1, 8'd0);
    for (int c = 0; c < 3 * FR && f < 2; c++) begin
      step();
      if (fs) f++;
      if (rect !== erect()) bad++;
      if (f >= 1 && rect === 1'b1) ones++;
    end
    checks++; if (bad != 0 || f != 2) $display("FAIL inverted_rect mismatching_cycles=%0d frames=%0d want 0/2", bad, f); else passed++;
    checks++; if (ones != 0) $display("FAIL inverted_never_on rect_cycles=%0d want 0", ones); else passed++;
  endtask

  task automatic test_random();
    int bad = 0, bad_fs = 0, rel;
    for (int c = 0; c < 2 * FR; c++) begin
      if ($urandom_range(0, 31) == 0) begin
        rel = int'($urandom_range(0, 11)) - 2;
        pid = 8'(int'(BASE) + rel);
        if (rel < 0 || rel > 7)   dat = 8'($urandom);
        else if (rel % 2 == 1)    dat = {6'($urandom), 1'b0, ($urandom_range(0, 7) == 0)};
        else if (rel < 4)         dat = 8'($urandom_range(0, 70));
        else                      dat = 8'($urandom_range(0, 24));
        we = 1'b1;
      end
      step();
      we = 1'b0;
      if (rect !== erect()) bad++;
      if (fs !== efs()) bad_fs++;
    end
    checks++; if (bad != 0) $display("FAIL random_rect mismatching_cycles=%0d want 0", bad); else passed++;
    checks++; if (bad_fs != 0) $display("FAIL random_frame_start mismatching_cycles=%0d want 0", bad_fs); else passed++;
  endtask

  task automatic test_midframe_reset();
    int f = 0, bad = 0, pre_ones = 0, first = -1, last = -1;
    for (int c = 0; c < 2 * FR && o_v != 10'd15; c++) step();
    checks++; if (o_v !== 10'd15) $display("FAIL reach_line15 got %0d want 15", o_v); else passed++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (o_h !== 10'd0) $display("FAIL midrst_hcount got %0d want 0", o_h); else passed++;
    checks++; if (o_v !== 10'd0) $display("FAIL midrst_vcount got %0d want 0", o_v); else passed++;
    checks++; if (hs !== 1'b1 || vs !== 1'b1) $display("FAIL midrst_sync got %b%b want 11", hs, vs); else passed++;
    checks++; if (tick !== 1'b0 || fs !== 1'b0) $display("FAIL midrst_tick_fs got %b%b want 00", tick, fs); else passed++;
    // Partial writes expose the reset bytes that are left untouched.
    wr(BASE + 8'd3, 8'd0); wr(BASE, 8'd5); wr(BASE + 8'd4, 8'd2); wr(BASE + 8'd7, 8'd0);
    for (int c = 0; c < 2 * FR && !(f == 1 && o_v > 10'd10); c++) begin
      step();
      if (fs) f++;
      if (rect !== erect()) bad++;
      if (f == 0 && rect === 1'b1) pre_ones++;
      if (f == 1 && rect && o_v == 10'd10) begin
        if (first < 0) first = int'(o_h);
        last = int'(o_h);
      end
    end
    checks++; if (bad != 0) $display("FAIL midrst_rect mismatching_cycles=%0d want 0", bad); else passed++;
    checks++; if (pre_ones != 0) $display("FAIL midrst_default_active rect_cycles=%0d want 0", pre_ones); else passed++;
    checks++; if (first != 6) $display("FAIL midrst_x0_reset_hi first_h=%0d want 6", first); else passed++;
    checks++; if (last != 37) $display("FAIL midrst_x1_reset_lo last_h=%0d want 37", last); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    k = 0;
    test_reset();
    test_timing();
    test_midframe_write();
    test_commit_collision();
    test_inverted_oob();
    test_random();
    test_midframe_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
